// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-word memory read, instruction register.
// Optional fetch timeout with sticky fault when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned   TIMEOUT  = 15
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch,
    input  logic          load_pc,
    input  logic [AW-1:0] pc_in,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rvalid,
    output logic [15:0]   instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;
    logic [15:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic          busy_q, busy_d;

    // A load_pc arriving in the final WAIT cycle beats any older pending target.
    logic          redirect_hit;
    logic [AW-1:0] redirect_pc;
    assign redirect_hit = load_pc | pend_q;
    assign redirect_pc  = load_pc ? pc_in : pend_pc_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        mem_addr_d    = mem_addr_q;
        mem_req_d     = 1'b0;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d         = cnt_q;
        fault_d       = fault_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (load_pc) begin
                    pc_d = pc_in;
                end
                if (fetch) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = load_pc ? pc_in : pc_q;
                end
            end

            S_REQ: begin
                if (load_pc) begin
                    pend_d    = 1'b1;
                    pend_pc_d = pc_in;
                end
                state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            S_WAIT: begin
                if (load_pc) begin
                    pend_d    = 1'b1;
                    pend_pc_d = pc_in;
                end
                if (mem_rvalid) begin
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    pc_d          = redirect_hit ? redirect_pc : pc_q + AW'(1);
                    pend_d        = 1'b0;
                    state_d       = S_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    if (redirect_hit) begin
                        pc_d = redirect_pc;
                    end
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pend_q        <= 1'b0;
            pend_pc_q     <= RESET_PC;
            mem_addr_q    <= RESET_PC;
            mem_req_q     <= 1'b0;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= cnt_d;
            fault_q       <= fault_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
`ifdef FETCH_TIMEOUT_EN
    assign fault       = fault_q;
`else
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic against a transaction-level model; covers FETCH_TIMEOUT_EN when defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch;
    logic        load_pc;
    logic [7:0]  pc_in;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;

`ifdef FETCH_TIMEOUT_EN
    localparam int TO = 15;
`endif

    instr_fetch_unit #(.AW(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .load_pc     (load_pc),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Model: expected outputs plus the age of the in-flight fetch
    // (-1 none, 0 request cycle, k = k-th cycle spent waiting for data).
    logic [7:0]  e_pc, e_addr, m_pend_pc;
    logic [15:0] e_instr;
    logic        e_valid, e_req, e_busy, e_fault, m_pend;
    int          m_age;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_next();
        if (reset) begin
            e_pc = 8'h00; e_instr = 16'h0000; e_valid = 1'b0; e_req = 1'b0;
            e_addr = 8'h00; e_fault = 1'b0; m_pend = 1'b0; m_pend_pc = 8'h00; m_age = -1;
        end else begin
            e_valid = 1'b0;
            e_req   = 1'b0;
            if (m_age < 0) begin
                if (load_pc) e_pc = pc_in;
                if (fetch) begin
                    m_age  = 0;
                    e_req  = 1'b1;
                    e_addr = e_pc;
                end
            end else begin
                if (load_pc) begin
                    m_pend    = 1'b1;
                    m_pend_pc = pc_in;
                end
                if (m_age == 0) begin
                    m_age = 1;
                end else if (mem_rvalid) begin
                    e_instr = mem_rdata;
                    e_valid = 1'b1;
                    e_pc    = m_pend ? m_pend_pc : e_pc + 8'd1;
                    m_pend  = 1'b0;
                    m_age   = -1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (m_age == TO) begin
                    e_fault = 1'b1;
                    if (m_pend) e_pc = m_pend_pc;
                    m_pend = 1'b0;
                    m_age  = -1;
                end
`endif
                else begin
                    m_age++;
                end
            end
        end
        e_busy = (m_age >= 0);
    endtask

    task automatic compare();
        check("pc",          {24'h0, pc},          {24'h0, e_pc});
        check("instr",       {16'h0, instr},       {16'h0, e_instr});
        check("instr_valid", {31'h0, instr_valid}, {31'h0, e_valid});
        check("mem_req",     {31'h0, mem_req},     {31'h0, e_req});
        check("mem_addr",    {24'h0, mem_addr},    {24'h0, e_addr});
        check("busy",        {31'h0, busy},        {31'h0, e_busy});
        check("fault",       {31'h0, fault},       {31'h0, e_fault});
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic f, input logic l, input logic [7:0] pin,
                        input logic rv, input logic [15:0] rd);
        reset = r; fetch = f; load_pc = l; pc_in = pin; mem_rvalid = rv; mem_rdata = rd;
        model_next();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    endtask

    logic [15:0] words [3];

    initial begin
        reset = 1'b1; fetch = 1'b0; load_pc = 1'b0; pc_in = 8'h00;
        mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        m_age = -1;
        words[0] = 16'hA0A0; words[1] = 16'hB1B1; words[2] = 16'hC2C2;
        @(posedge clk);
        #1;

        // Reset values
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("rst_pc",    {24'h0, pc},       32'h00);
        check("rst_instr", {16'h0, instr},    32'h0000);
        check("rst_busy",  {31'h0, busy},     32'h0);
        check("rst_addr",  {24'h0, mem_addr}, 32'h00);

        // Single fetch, memory answers two cycles after mem_req
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("t1_req",  {31'h0, mem_req},  32'h1);
        check("t1_addr", {24'h0, mem_addr}, 32'h00);
        idle();
        idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hD105);
        check("t1_instr", {16'h0, instr},       32'hD105);
        check("t1_valid", {31'h0, instr_valid}, 32'h1);
        check("t1_pc",    {24'h0, pc},          32'h01);
        check("t1_busy",  {31'h0, busy},        32'h0);
        idle();
        check("t1_valid_drop", {31'h0, instr_valid}, 32'h0);

        // Three back-to-back fetches with 1-cycle memory
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
            idle();
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, words[k]);
            check("t2_instr", {16'h0, instr},       {16'h0, words[k]});
            check("t2_valid", {31'h0, instr_valid}, 32'h1);
            check("t2_pc",    {24'h0, pc},          32'(k + 1));
        end

        // load_pc during WAIT: word from old address, then redirect
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 16'h0000);
        check("t3_pc_load", {24'h0, pc}, 32'h05);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("t3_addr", {24'h0, mem_addr}, 32'h05);
        idle();
        step(1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 16'h0000);
        check("t3_pc_hold", {24'h0, pc}, 32'h05);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h5A5A);
        check("t3_instr", {16'h0, instr}, 32'h5A5A);
        check("t3_pc",    {24'h0, pc},    32'h40);

        // PC wrap, then fetch + load_pc in the same IDLE cycle
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234);
        check("t4_wrap", {24'h0, pc}, 32'h00);
        step(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 16'h0000);
        check("t4_req",  {31'h0, mem_req},  32'h1);
        check("t4_addr", {24'h0, mem_addr}, 32'h10);
        idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h7777);
        check("t4_pc", {24'h0, pc}, 32'h11);

        // Reset in WAIT abandons the fetch; late mem_rvalid ignored
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        idle();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFF);
        check("t5_instr", {16'h0, instr},       32'h0000);
        check("t5_valid", {31'h0, instr_valid}, 32'h0);
        check("t5_pc",    {24'h0, pc},          32'h00);
        check("t5_busy",  {31'h0, busy},        32'h0);

`ifdef FETCH_TIMEOUT_EN
        // Timeout after 15 silent WAIT cycles; fault sticky until reset
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        idle();
        for (int k = 0; k < TO - 1; k++) idle();
        check("t6_busy_pre",  {31'h0, busy},  32'h1);
        check("t6_fault_pre", {31'h0, fault}, 32'h0);
        idle();
        check("t6_fault", {31'h0, fault}, 32'h1);
        check("t6_busy",  {31'h0, busy},  32'h0);
        check("t6_pc",    {24'h0, pc},    32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hABCD);
        check("t6_fault_sticky", {31'h0, fault}, 32'h1);
        check("t6_pc_after",     {24'h0, pc},    32'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        check("t6_fault_clr", {31'h0, fault}, 32'h0);
`else
        // Without the timeout, WAIT holds indefinitely
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        idle();
        for (int k = 0; k < 30; k++) idle();
        check("t6_busy",  {31'h0, busy},  32'h1);
        check("t6_fault", {31'h0, fault}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'hABCD);
        check("t6_pc", {24'h0, pc}, 32'h01);
`endif

        // Randomized traffic; slow-memory phases alternate with fast ones
        for (int i = 0; i < 3000; i++) begin
            logic r, f, l, rv;
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 4) == 0);
            rv = ((i / 200) % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            step(r, f, l, 8'($urandom), rv, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
